cipher_byte_serializer: RTL and testbench

Downstream stage of the 128-bit `cipher` block.
- Consumes ciphered blocks through the cipher's `data_o`/`valid_o`/`ack_i` handshake and buffers them in a small FIFO.
- Emits each block as 16 bytes, MSB first, on a valid/ready byte stream toward the output interface (UART/byte sink).
- Frees the cipher for the next block as soon as a buffer slot is available, so ciphering overlaps serialization.

---
 rtl/cipher_byte_serializer.sv | 109 ++++++++++
 tb/tb_cipher_byte_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_byte_serializer.sv
// cipher_byte_serializer: buffers 128-bit ciphered blocks in a small FIFO and
// streams each one out as 16 bytes, MSB first, on a valid/ready byte port.
// The cipher is acknowledged as soon as a slot is free, so ciphering of the
// next block overlaps serialization of the current one.
module cipher_byte_serializer #(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic [127:0] data_i,
  input  logic         valid_i,
  output logic         ack_o,
  output logic [7:0]   byte_o,
  output logic         byte_valid_o,
  input  logic         byte_ready_i,
  output logic         last_o,
  output logic         busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       mem_q [DEPTH];
  logic [127:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [3:0]         idx_q, idx_d;

  logic               capture;
  logic               xfer;
  logic               pop;
  logic [127:0]       head;
  logic [6:0]         bit_lo;

  // Byte 0 sits in bits 127:120, so the low bit of byte idx is 8*(15-idx);
  // for a 4-bit index 15-idx is simply its bitwise inverse.
  assign head         = mem_q[rd_ptr_q];
  assign bit_lo       = {~idx_q, 3'b000};
  assign byte_o       = head[bit_lo +: 8];
  assign byte_valid_o = (count_q != '0);
  assign last_o       = byte_valid_o & (idx_q == 4'd15);
  assign ack_o        = (state_q == ST_ACK);
  assign busy_o       = byte_valid_o | ack_o;

  // Next-state logic: capture gated by the ACK state and by the pre-edge count,
  // byte index advance and pop on the block's final transfer.
  always_comb begin
    capture  = valid_i & (state_q == ST_IDLE) & (count_q != CNT_W'(DEPTH));
    xfer     = byte_valid_o & byte_ready_i;
    pop      = xfer & (idx_q == 4'd15);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    state_d  = capture ? ST_ACK : ST_IDLE;

    if (capture) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (xfer) begin
      idx_d = idx_q + 4'd1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({capture, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every buffered block and partial byte index.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cipher_byte_serializer.sv
// Bench for cipher_byte_serializer: a queue-based block model checked every
// cycle, plus directed scenarios with hand-computed byte streams and timing.
module tb_cipher_byte_serializer;

  localparam int DEPTH = 2;

  localparam logic [127:0] BLK1 = 128'h3ee5c99f9a41c389ac17b4fe99c72ae4;
  localparam logic [127:0] BLKA = 128'h79cf5a10e3b40f278d66c1a204be1ccd;
  localparam logic [127:0] BLKB = 128'h63a17e29b0c458d312ef9a0764f8cd03;
  localparam logic [127:0] BLKC = 128'h2ed04b8cf1953a6e07d2c4b158a39a9d;
  localparam logic [127:0] BLKD = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] BLKR = 128'h74f245305909226922ac9d24b9ed3b20;

  logic         clk = 1'b0;
  logic         resetn_i = 1'b1;
  logic [127:0] data_i = '0;
  logic         valid_i = 1'b0;
  logic         ack_o;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         byte_ready_i = 1'b0;
  logic         last_o;
  logic         busy_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int ack_cyc = 0;

  logic [7:0] rx_b[$];
  bit         rx_last[$];
  int         rx_cyc[$];

  logic [7:0] exp1 [16] = '{8'h3e, 8'he5, 8'hc9, 8'h9f, 8'h9a, 8'h41, 8'hc3, 8'h89,
                            8'hac, 8'h17, 8'hb4, 8'hfe, 8'h99, 8'hc7, 8'h2a, 8'he4};

  always #5 clk = ~clk;

  cipher_byte_serializer #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .resetn_i     (resetn_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ack_o        (ack_o),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a queue of whole blocks, a byte position in the head block and the
  // acknowledge flag; blocks enter when offered, not just acked, and room exists.
  logic [127:0] mq[$];
  int           midx = 0;
  bit           mack = 1'b0;
  bit           m_cap, m_xf;

  always @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      mq.delete();
      midx = 0;
      mack = 1'b0;
    end else begin
      m_cap = valid_i && !mack && (mq.size() < DEPTH);
      m_xf  = (mq.size() != 0) && byte_ready_i;
      if (m_xf) begin
        if (midx == 15) begin
          midx = 0;
          void'(mq.pop_front());
        end else begin
          midx++;
        end
      end
      if (m_cap) mq.push_back(data_i);
      mack = m_cap;
    end
  end

  // Per-cycle compare against the model, stability check and transfer log.
  bit         hold_v = 1'b0;
  logic [7:0] hold_b;
  logic       hold_l;
  bit         e_bv;

  always @(negedge clk) begin
    cyc++;
    e_bv = (mq.size() != 0);
    chk("ack", ack_o, mack);
    chk("byte_valid", byte_valid_o, e_bv);
    chk("last", last_o, e_bv && (midx == 15));
    chk("busy", busy_o, e_bv || mack);
    if (e_bv) chk("byte", byte_o, (mq[0] >> (120 - 8 * midx)) & 128'hff);
    if (!resetn_i) chk("byte_in_reset", byte_o, 8'h00);
    if (hold_v && byte_valid_o) begin
      chk("byte_hold", byte_o, hold_b);
      chk("last_hold", last_o, hold_l);
    end
    hold_v = byte_valid_o && !byte_ready_i;
    hold_b = byte_o;
    hold_l = last_o;
    if (ack_o) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
    if (byte_valid_o && byte_ready_i) begin
      rx_b.push_back(byte_o);
      rx_last.push_back(last_o);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [127:0] d);
    int n;
    n = 0;
    data_i  = d;
    valid_i = 1'b1;
    do begin
      tick();
      n++;
    end while (!ack_o && n < 60);
    chk("ack_timeout", ack_o, 1'b1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", busy_o, 1'b0);
  endtask

  task automatic chk_block(input string nm, input int at, input logic [127:0] blk);
    for (int j = 0; j < 16; j++) begin
      chk(nm, rx_b[at + j], (blk >> (120 - 8 * j)) & 128'hff);
      chk({nm, "_last"}, rx_last[at + j], j == 15);
    end
  endtask

  int base, base2, a0, n;

  initial begin
    // Reset held two cycles with an offered block and a ready sink
    #1;
    resetn_i     = 1'b0;
    valid_i      = 1'b1;
    byte_ready_i = 1'b1;
    data_i       = BLK1;
    tick();
    tick();
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_bv", byte_valid_o, 1'b0);
    chk("rst_last", last_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_byte", byte_o, 8'h00);
    valid_i  = 1'b0;
    resetn_i = 1'b1;
    tick();
    tick();
    chk("rst_no_capture", busy_o, 1'b0);
    chk("rst_no_ack", ack_cnt, 0);

    // Single block, sink always ready
    base = rx_b.size();
    a0   = ack_cnt;
    offer(BLK1);
    drain();
    chk("single_acks", ack_cnt - a0, 1);
    chk("single_count", rx_b.size() - base, 16);
    if (rx_b.size() - base >= 16) begin
      for (int j = 0; j < 16; j++) begin
        chk("single_byte", rx_b[base + j], exp1[j]);
        chk("single_last", rx_last[base + j], j == 15);
      end
      chk("single_span", rx_cyc[base + 15] - rx_cyc[base], 15);
    end

    // Back-pressure: ready alternates starting high on the first valid cycle
    base         = rx_b.size();
    a0           = ack_cnt;
    byte_ready_i = 1'b0;
    data_i       = BLK1;
    valid_i      = 1'b1;
    n            = 0;
    while ((rx_b.size() - base) < 16 && n < 80) begin
      tick();
      n++;
      if (ack_o) valid_i = 1'b0;
      byte_ready_i = ~byte_ready_i;
    end
    byte_ready_i = 1'b1;
    drain();
    chk("bp_acks", ack_cnt - a0, 1);
    chk("bp_count", rx_b.size() - base, 16);
    if (rx_b.size() - base >= 16) begin
      chk_block("bp_byte", base, BLK1);
      chk("bp_span", rx_cyc[base + 15] - rx_cyc[base], 30);
    end

    // Full FIFO: two blocks accepted, third held until the first block pops
    base         = rx_b.size();
    a0           = ack_cnt;
    byte_ready_i = 1'b0;
    offer(BLKA);
    tick();
    offer(BLKB);
    data_i  = BLKC;
    valid_i = 1'b1;
    repeat (6) tick();
    chk("full_held_ack", ack_o, 1'b0);
    chk("full_acks", ack_cnt - a0, 2);
    chk("full_first_byte", byte_o, 8'h79);
    byte_ready_i = 1'b1;
    n = 0;
    while (!ack_o && n < 60) begin
      tick();
      n++;
    end
    chk("full_ack_timeout", ack_o, 1'b1);
    valid_i = 1'b0;
    tick();
    drain();
    chk("full_acks_total", ack_cnt - a0, 3);
    chk("full_count", rx_b.size() - base, 48);
    if (rx_b.size() - base >= 48) begin
      chk("full_ack_delay", ack_cyc - rx_cyc[base + 15], 2);
      chk("full_order0", rx_b[base], 8'h79);
      chk("full_order1", rx_b[base + 16], 8'h63);
      chk("full_order2", rx_b[base + 32], 8'h2e);
      chk_block("full_a", base, BLKA);
      chk_block("full_b", base + 16, BLKB);
      chk_block("full_c", base + 32, BLKC);
      chk("full_stream_gap", rx_cyc[base + 47] - rx_cyc[base + 16], 31);
    end

    // Valid held high three cycles past the capture: presented again after ACK
    base         = rx_b.size();
    a0           = ack_cnt;
    byte_ready_i = 1'b1;
    data_i       = BLKD;
    valid_i      = 1'b1;
    n = 0;
    while (!ack_o && n < 60) begin
      tick();
      n++;
    end
    chk("held_ack_timeout", ack_o, 1'b1);
    repeat (3) tick();
    valid_i = 1'b0;
    drain();
    chk("held_acks", ack_cnt - a0, 2);
    chk("held_count", rx_b.size() - base, 32);
    if (rx_b.size() - base >= 32) begin
      chk_block("held_b0", base, BLKD);
      chk_block("held_b1", base + 16, BLKD);
      chk("held_no_gap", rx_cyc[base + 16] - rx_cyc[base + 15], 1);
    end

    // Asynchronous reset between edges after byte 5 has transferred
    base         = rx_b.size();
    byte_ready_i = 1'b1;
    data_i       = BLK1;
    valid_i      = 1'b1;
    n = 0;
    while ((rx_b.size() - base) < 6 && n < 60) begin
      tick();
      n++;
      if (ack_o) valid_i = 1'b0;
    end
    #2;
    resetn_i = 1'b0;
    #1;
    chk("arst_ack", ack_o, 1'b0);
    chk("arst_bv", byte_valid_o, 1'b0);
    chk("arst_last", last_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_byte", byte_o, 8'h00);
    data_i  = BLKR;
    valid_i = 1'b1;
    tick();
    tick();
    chk("arst_partial", rx_b.size() - base, 6);
    #2;
    resetn_i = 1'b1;
    base2    = rx_b.size();
    a0       = ack_cnt;
    n = 0;
    while (!ack_o && n < 60) begin
      tick();
      n++;
    end
    chk("arst_ack_timeout", ack_o, 1'b1);
    valid_i = 1'b0;
    drain();
    chk("arst_acks", ack_cnt - a0, 1);
    chk("arst_count", rx_b.size() - base2, 16);
    if (rx_b.size() - base2 >= 16) begin
      chk("arst_first", rx_b[base2], 8'h74);
      chk_block("arst_blk", base2, BLKR);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
